// File: rtl/axis_chk_pkg.sv
// Shared types and constants for the AXI-Stream checker: FSM states, LFSR taps,
// throttle encodings and the throttle-to-ready decode.
package axis_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

  // Right-shifting Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (maximal length)
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  localparam logic [1:0] THR_FULL = 2'd0;
  localparam logic [1:0] THR_3Q   = 2'd1;
  localparam logic [1:0] THR_HALF = 2'd2;
  localparam logic [1:0] THR_1Q   = 2'd3;

  function automatic logic ready_decode(input logic [1:0] thr, input logic [1:0] top);
    logic rdy;
    case (thr)
      THR_FULL: rdy = 1'b1;
      THR_3Q:   rdy = ~(top[1] & top[0]);
      THR_HALF: rdy = top[1];
      default:  rdy = top[1] & top[0];
    endcase
    return rdy;
  endfunction

endpackage

// File: rtl/axis_ready_lfsr.sv
// Seeded Galois LFSR producing the pseudo-random ready pattern; ready_next is the
// decode of the value the LFSR will hold after the coming edge.
module axis_ready_lfsr
  import axis_chk_pkg::*;
#(
  parameter int LFSR_WIDTH = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_reset_n,
  input  logic                  load,
  input  logic [LFSR_WIDTH-1:0] seed,
  input  logic                  advance,
  input  logic [1:0]            throttle,
  output logic                  ready_next
);

  localparam logic [LFSR_WIDTH-1:0] POLY = LFSR_WIDTH'(LFSR_POLY);

  logic [LFSR_WIDTH-1:0] r_lfsr;
  logic [LFSR_WIDTH-1:0] w_lfsr_d;

  // An all-zero state would lock up the LFSR, so a zero seed becomes 1
  always_comb begin
    w_lfsr_d = r_lfsr;
    if (load) begin
      w_lfsr_d = (seed == '0) ? LFSR_WIDTH'(1) : seed;
    end else if (advance) begin
      w_lfsr_d = (r_lfsr >> 1) ^ (r_lfsr[0] ? POLY : '0);
    end
  end

  always_ff @(posedge rd_clk or negedge rd_reset_n) begin
    if (!rd_reset_n) begin
      r_lfsr <= LFSR_WIDTH'(1);
    end else begin
      r_lfsr <= w_lfsr_d;
    end
  end

  assign ready_next = ready_decode(throttle, w_lfsr_d[LFSR_WIDTH-1 -: 2]);

endmodule

// File: rtl/axis_stream_checker.sv
// Read-side AXI-Stream consumer: LFSR backpressure, incrementing-sequence check,
// counters and first-error capture. Optional stall timeout: AXIS_CHECKER_TIMEOUT_EN.
module axis_stream_checker
  import axis_chk_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int CNT_WIDTH      = 16,
  parameter int LFSR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  rd_clk,
  input  logic                  rd_reset_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  expected_count,
  input  logic [DATA_WIDTH-1:0] init_value,
  input  logic [LFSR_WIDTH-1:0] seed,
  input  logic [1:0]            throttle,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  input  logic                  s_axis_valid,
  output logic                  s_axis_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [CNT_WIDTH-1:0]  error_count,
  output logic [CNT_WIDTH-1:0]  first_err_index,
  output logic [DATA_WIDTH-1:0] first_err_data,
  output logic [DATA_WIDTH-1:0] first_err_exp
`ifdef AXIS_CHECKER_TIMEOUT_EN
  ,
  output logic                  timeout
`endif
);

  chk_state_t            r_state;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;
  logic [CNT_WIDTH-1:0]  r_beat;
  logic [CNT_WIDTH-1:0]  r_err;
  logic [CNT_WIDTH-1:0]  r_fidx;
  logic [DATA_WIDTH-1:0] r_fdat;
  logic [DATA_WIDTH-1:0] r_fexp;
  logic [DATA_WIDTH-1:0] r_exp_data;
  logic [CNT_WIDTH-1:0]  r_exp_count;

  logic w_start_ok;
  logic w_accept;
  logic w_mismatch;
  logic w_last;
  logic w_timeout_hit;
  logic w_go_run;
  logic w_ready_next;

  assign w_start_ok = start && (r_state != RUN);
  assign w_accept   = s_axis_valid && r_ready;
  assign w_mismatch = w_accept && (s_axis_data != r_exp_data);
  assign w_last     = w_accept && ((r_beat + CNT_WIDTH'(1)) == r_exp_count);

`ifdef AXIS_CHECKER_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0] r_stall;
  logic               r_timeout;

  assign w_timeout_hit = (r_state == RUN) && !w_accept &&
                         (r_stall == STALL_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge rd_clk or negedge rd_reset_n) begin
    if (!rd_reset_n) begin
      r_stall   <= '0;
      r_timeout <= 1'b0;
    end else if (w_start_ok) begin
      r_stall   <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == RUN) begin
      if (w_accept) begin
        r_stall <= '0;
      end else if (w_timeout_hit) begin
        r_timeout <= 1'b1;
      end else begin
        r_stall <= r_stall + STALL_W'(1);
      end
    end
  end

  assign timeout = r_timeout;
`else
  // Stalls never end a run in this build
  assign w_timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  assign w_go_run = (w_start_ok && (expected_count != '0)) ||
                    ((r_state == RUN) && !w_last && !w_timeout_hit);

  axis_ready_lfsr #(
    .LFSR_WIDTH (LFSR_WIDTH)
  ) u_lfsr (
    .rd_clk     (rd_clk),
    .rd_reset_n (rd_reset_n),
    .load       (w_start_ok),
    .seed       (seed),
    .advance    (r_state == RUN),
    .throttle   (throttle),
    .ready_next (w_ready_next)
  );

  always_ff @(posedge rd_clk or negedge rd_reset_n) begin
    if (!rd_reset_n) begin
      r_state     <= IDLE;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_beat      <= '0;
      r_err       <= '0;
      r_fidx      <= '0;
      r_fdat      <= '0;
      r_fexp      <= '0;
      r_exp_data  <= '0;
      r_exp_count <= '0;
    end else begin
      r_ready <= w_go_run && w_ready_next;
      if (w_start_ok) begin
        r_beat      <= '0;
        r_err       <= '0;
        r_fidx      <= '0;
        r_fdat      <= '0;
        r_fexp      <= '0;
        r_exp_data  <= init_value;
        r_exp_count <= expected_count;
        if (expected_count == '0) begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= 1'b1;
        end else begin
          r_state <= RUN;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      end else if (r_state == RUN) begin
        if (w_accept) begin
          r_beat     <= r_beat + CNT_WIDTH'(1);
          r_exp_data <= r_exp_data + DATA_WIDTH'(1);
          if (w_mismatch) begin
            if (r_err != '1) begin
              r_err <= r_err + CNT_WIDTH'(1);
            end
            if (r_err == '0) begin
              r_fidx <= r_beat;
              r_fdat <= s_axis_data;
              r_fexp <= r_exp_data;
            end
          end
        end
        // The error count seen here excludes the final beat, hence the extra term
        if (w_last || w_timeout_hit) begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= !w_timeout_hit && (r_err == '0) && !w_mismatch;
        end
      end
    end
  end

  assign s_axis_ready    = r_ready;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign beat_count      = r_beat;
  assign error_count     = r_err;
  assign first_err_index = r_fidx;
  assign first_err_data  = r_fdat;
  assign first_err_exp   = r_fexp;

endmodule

// File: tb/tb_axis_stream_checker.sv
// Randomized self-checking bench for axis_stream_checker with a sequence reference model.
module tb_axis_stream_checker;
  localparam int DW = 8;
  localparam int CW = 16;
  localparam int LW = 16;

  logic          rd_clk = 1'b0;
  logic          rd_reset_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] expected_count = '0;
  logic [DW-1:0] init_value = '0;
  logic [LW-1:0] seed = '0;
  logic [1:0]    throttle = '0;
  logic [DW-1:0] s_axis_data = '0;
  logic          s_axis_valid = 1'b0;
  logic          s_axis_ready, busy, done, pass;
  logic [CW-1:0] beat_count, error_count, first_err_index;
  logic [DW-1:0] first_err_data, first_err_exp;
`ifdef AXIS_CHECKER_TIMEOUT_EN
  logic          timeout;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] tx[$];

  always #5 rd_clk = ~rd_clk;

  axis_stream_checker #(
    .DATA_WIDTH(DW), .CNT_WIDTH(CW), .LFSR_WIDTH(LW), .TIMEOUT_CYCLES(64)
  ) dut (
    .rd_clk(rd_clk), .rd_reset_n(rd_reset_n), .start(start),
    .expected_count(expected_count), .init_value(init_value), .seed(seed),
    .throttle(throttle), .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid),
    .s_axis_ready(s_axis_ready), .busy(busy), .done(done), .pass(pass),
    .beat_count(beat_count), .error_count(error_count),
    .first_err_index(first_err_index), .first_err_data(first_err_data),
    .first_err_exp(first_err_exp)
`ifdef AXIS_CHECKER_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  task automatic fill_seq(input int n, input logic [7:0] init);
    tx.delete();
    for (int i = 0; i < n; i++) tx.push_back(8'((int'(init) + i) % 256));
  endtask

  // Reference: beat i must equal (init + i) mod 256; first mismatch is captured
  task automatic model(input int n, input logic [7:0] init, output int errs, output int fidx,
                       output logic [7:0] fdat, output logic [7:0] fexp);
    logic [7:0] e;
    errs = 0; fidx = 0; fdat = 0; fexp = 0;
    for (int i = 0; i < n; i++) begin
      e = 8'((int'(init) + i) % 256);
      if (tx[i] !== e) begin
        if (errs == 0) begin fidx = i; fdat = tx[i]; fexp = e; end
        errs++;
      end
    end
  endtask

  task automatic do_start(input logic [15:0] cnt, input logic [7:0] init,
                          input logic [15:0] sd, input logic [1:0] thr);
    @(negedge rd_clk);
    expected_count = cnt; init_value = init; seed = sd; throttle = thr; start = 1'b1;
    @(negedge rd_clk);
    start = 1'b0;
  endtask

  // Source with random valid gaps; returns at the negedge after the stop_at-th accept
  task automatic stream(input int first, input int stop_at, input int maxgap,
                        output int cyc, output int rdy_cyc, output int run_cyc, output bit ok);
    int acc;
    int gap;
    bit pend;
    acc = first; cyc = 0; rdy_cyc = 0; run_cyc = 0; pend = 0; ok = 1;
    gap = int'($urandom_range(0, maxgap));
    while (acc < stop_at) begin
      @(negedge rd_clk);
      if (pend) acc++;
      if (acc >= stop_at) break;
      if (cyc >= 20000) begin ok = 0; break; end
      cyc++;
      if (busy) begin
        run_cyc++;
        if (s_axis_ready) rdy_cyc++;
      end
      if (gap > 0) begin
        s_axis_valid = 1'b0; s_axis_data = 8'($urandom); gap--;
      end else begin
        s_axis_valid = 1'b1; s_axis_data = tx[acc];
      end
      pend = s_axis_valid && s_axis_ready;
      if (pend) gap = int'($urandom_range(0, maxgap));
    end
    s_axis_valid = 1'b0;
  endtask

  task automatic test_reset();
    rd_reset_n = 1'b0;
    repeat (2) @(negedge rd_clk);
    n_tests++;
    if ({s_axis_ready, busy, done, pass, beat_count, error_count, first_err_index,
         first_err_data, first_err_exp} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b busy=%b done=%b pass=%b beats=%0d errs=%0d, want all 0",
               s_axis_ready, busy, done, pass, beat_count, error_count);
    end
    rd_reset_n = 1'b1;
    @(negedge rd_clk);
  endtask

  task automatic test_basic();
    int cyc, rc, runc; bit ok;
    fill_seq(10, 8'h00);
    do_start(16'd10, 8'h00, 16'($urandom), 2'd0);
    stream(0, 10, 0, cyc, rc, runc, ok);
    n_tests++;
    if (ok !== 1'b1 || cyc !== 10) begin
      n_fail++; $display("FAIL basic_cycles: got %0d cycles ok=%b, want 10", cyc, ok);
    end
    n_tests++;
    if ({done, pass, busy, s_axis_ready} !== 4'b1100) begin
      n_fail++; $display("FAIL basic_flags: got done/pass/busy/rdy=%b%b%b%b, want 1100",
                         done, pass, busy, s_axis_ready);
    end
    n_tests++;
    if (beat_count !== 16'd10 || error_count !== 16'd0) begin
      n_fail++; $display("FAIL basic_counts: got beats=%0d errs=%0d, want 10/0", beat_count, error_count);
    end
  endtask

  task automatic test_idle_ignore();
    int rdy_seen = 0;
    logic [15:0] b0;
    b0 = beat_count;
    for (int i = 0; i < 5; i++) begin
      @(negedge rd_clk);
      s_axis_valid = 1'b1; s_axis_data = 8'($urandom);
      if (s_axis_ready) rdy_seen++;
    end
    @(negedge rd_clk);
    s_axis_valid = 1'b0;
    n_tests++;
    if (rdy_seen !== 0 || beat_count !== b0 || done !== 1'b1) begin
      n_fail++; $display("FAIL idle_ignore: got ready_cycles=%0d beats=%0d done=%b, want 0/%0d/1",
                         rdy_seen, beat_count, done, b0);
    end
  endtask

  task automatic test_wrap();
    int cyc, rc, runc; bit ok;
    fill_seq(8, 8'hFC);
    do_start(16'd8, 8'hFC, 16'($urandom), 2'd2);
    stream(0, 8, 2, cyc, rc, runc, ok);
    n_tests++;
    if (ok !== 1'b1 || {done, pass} !== 2'b11 || beat_count !== 16'd8 || error_count !== 16'd0) begin
      n_fail++; $display("FAIL wrap: got ok=%b done=%b pass=%b beats=%0d errs=%0d, want 1/1/1/8/0",
                         ok, done, pass, beat_count, error_count);
    end
  endtask

  task automatic test_errors();
    int cyc, rc, runc, errs, fidx; bit ok;
    logic [7:0] fdat, fexp;
    tx.delete();
    tx.push_back(8'h00); tx.push_back(8'h01); tx.push_back(8'h02);
    tx.push_back(8'h07); tx.push_back(8'h04); tx.push_back(8'h09);
    model(6, 8'h00, errs, fidx, fdat, fexp);
    do_start(16'd6, 8'h00, 16'($urandom), 2'd1);
    stream(0, 6, 1, cyc, rc, runc, ok);
    n_tests++;
    if (ok !== 1'b1 || error_count !== 16'(errs) || errs != 2) begin
      n_fail++; $display("FAIL err_count: got %0d, want %0d (=2)", error_count, errs);
    end
    n_tests++;
    if (first_err_index !== 16'(fidx) || first_err_data !== fdat || first_err_exp !== fexp) begin
      n_fail++; $display("FAIL err_capture: got idx=%0d data=%h exp=%h, want %0d/%h/%h",
                         first_err_index, first_err_data, first_err_exp, fidx, fdat, fexp);
    end
    n_tests++;
    if ({done, pass} !== 2'b10) begin
      n_fail++; $display("FAIL err_pass: got done=%b pass=%b, want 1/0", done, pass);
    end
  endtask

  task automatic test_throttle_quarter();
    int cyc, rc, runc, duty; bit ok;
    logic [7:0] init;
    init = 8'($urandom);
    fill_seq(200, init);
    do_start(16'd200, init, 16'hACE1, 2'd3);
    stream(0, 200, 5, cyc, rc, runc, ok);
    duty = (runc > 0) ? (rc * 100) / runc : 0;
    n_tests++;
    if (ok !== 1'b1 || duty < 15 || duty > 35) begin
      n_fail++; $display("FAIL quarter_duty: got %0d%% (ok=%b), want 15..35", duty, ok);
    end
    n_tests++;
    if (beat_count !== 16'd200 || error_count !== 16'd0 || {done, pass} !== 2'b11) begin
      n_fail++; $display("FAIL quarter_result: got beats=%0d errs=%0d done=%b pass=%b, want 200/0/1/1",
                         beat_count, error_count, done, pass);
    end
  endtask

  task automatic test_random_errors();
    int cyc, rc, runc, errs, fidx; bit ok;
    logic [7:0] fdat, fexp, init;
    init = 8'($urandom);
    fill_seq(60, init);
    for (int i = 0; i < 60; i++)
      if ($urandom_range(0, 7) == 0) tx[i] = tx[i] ^ 8'($urandom_range(1, 255));
    model(60, init, errs, fidx, fdat, fexp);
    do_start(16'd60, init, 16'($urandom), 2'($urandom));
    stream(0, 60, 3, cyc, rc, runc, ok);
    n_tests++;
    if (ok !== 1'b1 || error_count !== 16'(errs) || pass !== (errs == 0)) begin
      n_fail++; $display("FAIL rand_errs: got errs=%0d pass=%b, want %0d/%b", error_count, pass,
                         errs, (errs == 0));
    end
    n_tests++;
    if (errs != 0 && (first_err_index !== 16'(fidx) || first_err_data !== fdat ||
                      first_err_exp !== fexp)) begin
      n_fail++; $display("FAIL rand_capture: got idx=%0d data=%h exp=%h, want %0d/%h/%h",
                         first_err_index, first_err_data, first_err_exp, fidx, fdat, fexp);
    end
  endtask

  task automatic test_start_in_run();
    int cyc, rc, runc; bit ok1, ok2;
    fill_seq(6, 8'h10);
    do_start(16'd6, 8'h10, 16'($urandom), 2'd1);
    stream(0, 2, 1, cyc, rc, runc, ok1);
    @(negedge rd_clk);
    expected_count = 16'd3; init_value = 8'h55; start = 1'b1;
    @(negedge rd_clk);
    start = 1'b0;
    stream(2, 6, 1, cyc, rc, runc, ok2);
    n_tests++;
    if (ok1 !== 1'b1 || ok2 !== 1'b1 || beat_count !== 16'd6 || error_count !== 16'd0 ||
        {done, pass} !== 2'b11) begin
      n_fail++; $display("FAIL start_in_run: got beats=%0d errs=%0d done=%b pass=%b, want 6/0/1/1",
                         beat_count, error_count, done, pass);
    end
  endtask

  task automatic test_zero_count();
    do_start(16'd0, 8'h33, 16'($urandom), 2'd0);
    n_tests++;
    if ({done, pass, busy, s_axis_ready} !== 4'b1100 || beat_count !== 16'd0) begin
      n_fail++; $display("FAIL zero_count: got done/pass/busy/rdy=%b%b%b%b beats=%0d, want 1100/0",
                         done, pass, busy, s_axis_ready, beat_count);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, rc, runc; bit ok;
    fill_seq(100, 8'h00);
    tx[10] = 8'hEE;
    do_start(16'd100, 8'h00, 16'($urandom), 2'd2);
    stream(0, 50, 2, cyc, rc, runc, ok);
    n_tests++;
    if (ok !== 1'b1 || beat_count !== 16'd50 || error_count !== 16'd1) begin
      n_fail++; $display("FAIL midrun_pre: got beats=%0d errs=%0d, want 50/1", beat_count, error_count);
    end
    rd_reset_n = 1'b0;
    #1;
    n_tests++;
    if ({s_axis_ready, busy, done, pass, beat_count, error_count, first_err_index,
         first_err_data, first_err_exp} !== '0) begin
      n_fail++; $display("FAIL midrun_reset: got rdy=%b busy=%b beats=%0d errs=%0d idx=%0d, want all 0",
                         s_axis_ready, busy, beat_count, error_count, first_err_index);
    end
    @(negedge rd_clk);
    rd_reset_n = 1'b1;
    fill_seq(20, 8'hA0);
    do_start(16'd20, 8'hA0, 16'($urandom), 2'($urandom));
    stream(0, 20, 2, cyc, rc, runc, ok);
    n_tests++;
    if (ok !== 1'b1 || beat_count !== 16'd20 || {done, pass} !== 2'b11) begin
      n_fail++; $display("FAIL midrun_rerun: got beats=%0d done=%b pass=%b, want 20/1/1",
                         beat_count, done, pass);
    end
  endtask

`ifdef AXIS_CHECKER_TIMEOUT_EN
  task automatic test_timeout();
    int cyc, rc, runc, wait_cyc; bit ok;
    fill_seq(10, 8'h00);
    do_start(16'd10, 8'h00, 16'($urandom), 2'd0);
    stream(0, 5, 0, cyc, rc, runc, ok);
    wait_cyc = 0;
    while (!done && wait_cyc < 200) begin
      @(negedge rd_clk);
      wait_cyc++;
    end
    n_tests++;
    if (ok !== 1'b1 || wait_cyc < 60 || wait_cyc > 70) begin
      n_fail++; $display("FAIL timeout_delay: got %0d cycles, want 60..70", wait_cyc);
    end
    n_tests++;
    if ({done, pass, timeout} !== 3'b101 || beat_count !== 16'd5) begin
      n_fail++; $display("FAIL timeout_flags: got done=%b pass=%b timeout=%b beats=%0d, want 1/0/1/5",
                         done, pass, timeout, beat_count);
    end
    do_start(16'd0, 8'h00, 16'h0001, 2'd0);
    n_tests++;
    if ({timeout, pass} !== 2'b01) begin
      n_fail++; $display("FAIL timeout_clear: got timeout=%b pass=%b, want 0/1", timeout, pass);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_idle_ignore();
    test_wrap();
    test_errors();
    test_throttle_quarter();
    test_random_errors();
    test_start_in_run();
    test_zero_count();
    test_reset_mid_run();
`ifdef AXIS_CHECKER_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_stream_checker.md
Name: axis_stream_checker

Overview:
- Read-side stream consumer that terminates the async FIFO's AXI-Stream master output (m_axis_top_*) in the rd_clk domain.
- Applies pseudo-random backpressure via an LFSR-driven ready and checks every accepted beat against an expected incrementing sequence.
- Reports beat count, error count, first-error capture and a pass/done verdict.
- Serves as the on-chip counterpart of the write-side stream source, for self-checking FIFO runs and hardware bring-up.

Parameters:
- DATA_WIDTH, 8, width of the stream data.
- CNT_WIDTH, 16, width of the beat and error counters and of expected_count.
- LFSR_WIDTH, 16, width of the backpressure LFSR.
- TIMEOUT_CYCLES, 1024, stall limit used only when the optional feature is compiled in.

Ports:
- rd_clk  in  1  read-domain clock; all logic on its rising edge.
- rd_reset_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  single-cycle pulse; begins a run; honoured only in IDLE or DONE.
- expected_count  in  CNT_WIDTH  number of beats in a run; sampled on start.
- init_value  in  DATA_WIDTH  expected value of the first beat; sampled on start.
- seed  in  LFSR_WIDTH  LFSR seed, loaded on start; value 0 is replaced by 1.
- throttle  in  2  ready duty: 0=always 1, 1=~3/4, 2=~1/2, 3=~1/4.
- s_axis_data  in  DATA_WIDTH  stream data (from m_axis_top_data).
- s_axis_valid  in  1  stream valid.
- s_axis_ready  out  1  stream ready (to m_axis_top_ready).
- busy  out  1  high in RUN.
- done  out  1  high in DONE; held until the next start.
- pass  out  1  valid when done: error_count==0 and no timeout.
- beat_count  out  CNT_WIDTH  number of accepted beats.
- error_count  out  CNT_WIDTH  number of mismatches; saturates at all-ones.
- first_err_index  out  CNT_WIDTH  beat index of the first mismatch.
- first_err_data  out  DATA_WIDTH  received data of the first mismatch.
- first_err_exp  out  DATA_WIDTH  expected data of the first mismatch.

Behaviour:
- Reset values: all outputs 0; state IDLE; LFSR=1; expected register=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE when the accepted beat makes beat_count equal expected_count.
  - DONE -> RUN on start.
  - A start pulse in RUN is ignored.
  - start with expected_count==0: go directly to DONE, pass=1.
- On start: clear beat_count, error_count, first_err_*; load expected register with init_value; load LFSR with seed.
- s_axis_ready is registered, low outside RUN.
- In RUN, s_axis_ready for the next cycle is decoded from the LFSR top two bits:
  - throttle 0: always 1.
  - throttle 1: 1 unless both bits are 1.
  - throttle 2: equals the top bit.
  - throttle 3: 1 only if both bits are 1.
- The LFSR advances every RUN cycle: Galois, polynomial from the package.
- Accept = s_axis_valid & s_axis_ready (standard AXIS handshake; valid independent of ready). On accept:
  - Compare s_axis_data with the expected register.
  - Increment beat_count.
  - Expected register increments modulo 2^DATA_WIDTH, so 0xFF wraps to 0x00.
  - On mismatch, increment error_count (saturating). If error_count was 0, capture first_err_index=beat_count (pre-increment), first_err_data and first_err_exp.
  - Counters and first-error capture update one cycle after the handshake edge.
- On the beat that completes the run, s_axis_ready drops the following cycle; done and pass are asserted the cycle after the final accept.
- Data offered while in IDLE or DONE is never accepted (ready=0).
- Reset asserted mid-run: immediate return to reset values; ready drops asynchronously.

Optional Feature:
- Macro: AXIS_CHECKER_TIMEOUT_EN.
- Defined:
  - A stall counter clears on each accept and on start, and increments in RUN otherwise.
  - On reaching TIMEOUT_CYCLES: go to DONE with pass=0.
  - Extra output timeout (1 bit, reset 0, cleared on start).
- Undefined: no stall counter, no timeout port; RUN waits indefinitely.

Decomposition:
- Package axis_chk_pkg:
  - state enum type chk_state_t {IDLE,RUN,DONE}.
  - LFSR tap constant LFSR_POLY (16'hB400).
  - throttle encoding localparams.
- Sub-module axis_ready_lfsr: seeded Galois LFSR plus the throttle-to-ready decode; ports rd_clk, rd_reset_n, load, seed, advance, throttle, ready_next.

Test Plan:
1. throttle=0, init_value=0x00, expected_count=10, source sends 0..9 with valid held high -> ready continuous; 10 accepts in 10 cycles; done=1, pass=1, beat_count=10, error_count=0.
2. init_value=0xFC, expected_count=8, source sends FC,FD,FE,FF,00,01,02,03 -> wraps cleanly; pass=1.
3. Source sends 0,1,2,7,4,9 against init_value=0 with expected_count=6 -> error_count=2, first_err_index=3, first_err_data=0x07, first_err_exp=0x03, pass=0.
4. throttle=3, seed=0xACE1, expected_count=200, source with random valid gaps (0-5 cycles) -> ready duty within 15-35%; no beat lost or duplicated; pass=1.
5. Reset pulled low at beat 50 of 100 -> all outputs 0 next sample, s_axis_ready=0; a following start with expected_count=20 runs to pass=1.
6. AXIS_CHECKER_TIMEOUT_EN, TIMEOUT_CYCLES=64, valid held low after 5 beats of 10 -> DONE after 64 idle cycles, timeout=1, pass=0, beat_count=5.
